// File: rtl/bridge_mailbox_if.sv
// Pocket bridge bus as seen by one leaf of the splitter.
// The bus clock travels with the bundle so the leaf needs no separate clock port.
interface bridge_if (
    input logic clk
);
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr;
    logic        rd;
    logic [31:0] rd_data;

    modport leaf (
        input  clk,
        input  addr,
        input  wr_data,
        input  wr,
        input  rd,
        output rd_data
    );

    modport host (
        input  clk,
        input  rd_data,
        output addr,
        output wr_data,
        output wr,
        output rd
    );
endinterface

// File: rtl/bridge_mailbox.sv
// Bridge leaf mailbox: host-to-core command FIFO and core-to-host response FIFO
// behind a four-word register window (DATA, STATUS, CTRL, ID).
module bridge_mailbox #(
    parameter int unsigned DEPTH      = 16,
    parameter logic [31:0] MAILBOX_ID = 32'h4D42_0001
) (
    bridge_if.leaf      bridge,
    input  logic        reset,
    output logic [31:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [31:0] rsp_data,
    input  logic        rsp_valid,
    output logic        rsp_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_ID     = 2'd3
    } reg_sel_t;

    logic clk;
    assign clk = bridge.clk;

    logic [31:0] cmd_mem [DEPTH];
    logic [31:0] rsp_mem [DEPTH];

    logic [PW-1:0] cmd_wr_ptr, cmd_rd_ptr, rsp_wr_ptr, rsp_rd_ptr;
    logic [CW-1:0] cmd_count, rsp_count;
    logic [CW-1:0] cmd_count_next, rsp_count_next;
    logic          ovf, unf;
    logic [31:0]   rd_data_q;

    reg_sel_t sel;
    logic     wr_en, rd_en;
    logic     data_wr, data_rd, status_wr, ctrl_wr;
    logic     cmd_flush, rsp_flush;
    logic     cmd_full, cmd_push, cmd_pop;
    logic     rsp_empty, rsp_push, rsp_pop;
    logic     ovf_set, unf_set, ovf_clr, unf_clr;
    logic [31:0] status_word;
    logic [31:0] rd_mux;

    // A simultaneous wr and rd is illegal on the bus; the write wins.
    assign sel       = reg_sel_t'(bridge.addr[3:2]);
    assign wr_en     = bridge.wr;
    assign rd_en     = bridge.rd && !bridge.wr;
    assign data_wr   = wr_en && (sel == REG_DATA);
    assign data_rd   = rd_en && (sel == REG_DATA);
    assign status_wr = wr_en && (sel == REG_STATUS);
    assign ctrl_wr   = wr_en && (sel == REG_CTRL);
    assign cmd_flush = ctrl_wr && bridge.wr_data[0];
    assign rsp_flush = ctrl_wr && bridge.wr_data[1];

    assign cmd_valid = (cmd_count != '0);
    assign cmd_full  = (cmd_count == CW'(DEPTH));
    assign cmd_pop   = cmd_valid && cmd_ready;
    // A full FIFO still takes a write when the core frees a slot in the same cycle.
    assign cmd_push  = data_wr && (!cmd_full || cmd_pop);
    assign ovf_set   = data_wr && cmd_full && !cmd_pop;
    assign cmd_data  = cmd_valid ? cmd_mem[cmd_rd_ptr] : 32'h0;

    assign rsp_empty = (rsp_count == '0);
    assign rsp_push  = rsp_valid && rsp_ready;
    assign rsp_pop   = data_rd && !rsp_empty;
    assign unf_set   = data_rd && rsp_empty;

    assign ovf_clr   = status_wr && bridge.wr_data[31];
    assign unf_clr   = status_wr && bridge.wr_data[30];

    assign bridge.rd_data = rd_data_q;

    assign status_word = {ovf, unf, 6'b0, 8'(rsp_count), 8'(cmd_count),
                          6'b0, !rsp_empty, cmd_full};

    always_comb begin
        cmd_count_next = cmd_count;
        unique case ({cmd_push, cmd_pop})
            2'b10:   cmd_count_next = cmd_count + CW'(1);
            2'b01:   cmd_count_next = cmd_count - CW'(1);
            default: cmd_count_next = cmd_count;
        endcase
        if (cmd_flush) cmd_count_next = '0;
    end

    always_comb begin
        rsp_count_next = rsp_count;
        unique case ({rsp_push, rsp_pop})
            2'b10:   rsp_count_next = rsp_count + CW'(1);
            2'b01:   rsp_count_next = rsp_count - CW'(1);
            default: rsp_count_next = rsp_count;
        endcase
        if (rsp_flush) rsp_count_next = '0;
    end

    always_comb begin
        rd_mux = 32'h0;
        unique case (sel)
            REG_DATA:   rd_mux = rsp_empty ? 32'h0 : rsp_mem[rsp_rd_ptr];
            REG_STATUS: rd_mux = status_word;
            REG_CTRL:   rd_mux = 32'h0;
            REG_ID:     rd_mux = MAILBOX_ID;
            default:    rd_mux = 32'h0;
        endcase
    end

    // NOTE: FIFO storage is deliberately left out of reset; the counts and pointers
    // define what is valid, and keeping the RAMs reset-free lets them map to memory.
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr] <= bridge.wr_data;
        if (rsp_push && !rsp_flush) rsp_mem[rsp_wr_ptr] <= rsp_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            cmd_count  <= '0;
            rsp_count  <= '0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            rd_data_q  <= 32'h0;
            rsp_ready  <= 1'b0;
        end else begin
            if (cmd_flush) begin
                cmd_wr_ptr <= '0;
                cmd_rd_ptr <= '0;
            end else begin
                if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + PW'(1);
                if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + PW'(1);
            end

            if (rsp_flush) begin
                rsp_wr_ptr <= '0;
                rsp_rd_ptr <= '0;
            end else begin
                if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + PW'(1);
                if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + PW'(1);
            end

            cmd_count <= cmd_count_next;
            rsp_count <= rsp_count_next;

            // Set beats clear when both land in the same cycle.
            ovf <= ovf_set || (ovf && !ovf_clr);
            unf <= unf_set || (unf && !unf_clr);

            if (rd_en) rd_data_q <= rd_mux;

            // Registered so it is low through reset; tracks "not full" of the next count.
            rsp_ready <= (rsp_count_next != CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_bridge_mailbox.sv
// Self-checking bench for bridge_mailbox: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the mailbox.
module tb_bridge_mailbox;
    localparam int          DEPTH = 16;
    localparam logic [31:0] ID    = 32'h4D42_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;

    always #5 clk = ~clk;

    bridge_if bus (.clk(clk));

    bridge_mailbox #(.DEPTH(DEPTH), .MAILBOX_ID(ID)) dut (
        .bridge    (bus),
        .reset     (reset),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] cmd_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] core_rx[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic        m_rsp_ready = 1'b0;
    logic [31:0] m_rd_data = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        return {m_ovf, m_unf, 6'b0, 8'(rsp_q.size()), 8'(cmd_q.size()),
                6'b0, rsp_q.size() > 0, cmd_q.size() == DEPTH};
    endfunction

    // One clock: evaluate the model on the pre-edge inputs, advance, compare outputs.
    task automatic step();
        logic [1:0]  sel;
        logic        wr_e, rd_e, c_pop, r_push, ovf_set, unf_set;
        logic [31:0] rd_val;
        sel    = bus.addr[3:2];
        wr_e   = bus.wr;
        rd_e   = bus.rd && !bus.wr;
        c_pop  = cmd_ready && (cmd_q.size() > 0);
        r_push = rsp_valid && m_rsp_ready;
        case (sel)
            2'd0:    rd_val = (rsp_q.size() > 0) ? rsp_q[0] : 32'h0;
            2'd1:    rd_val = model_status();
            2'd2:    rd_val = 32'h0;
            default: rd_val = ID;
        endcase
        if (c_pop && cmd_valid) core_rx.push_back(cmd_data);

        @(posedge clk);
        #1;

        if (reset) begin
            cmd_q.delete();
            rsp_q.delete();
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
            m_rsp_ready = 1'b0;
            m_rd_data   = 32'h0;
        end else begin
            ovf_set = wr_e && sel == 2'd0 && cmd_q.size() == DEPTH && !c_pop;
            unf_set = rd_e && sel == 2'd0 && rsp_q.size() == 0;
            if (c_pop) void'(cmd_q.pop_front());
            if (wr_e && sel == 2'd0 && !ovf_set) cmd_q.push_back(bus.wr_data);
            if (wr_e && sel == 2'd2 && bus.wr_data[0]) cmd_q.delete();
            if (rd_e && sel == 2'd0 && rsp_q.size() > 0) void'(rsp_q.pop_front());
            if (r_push) rsp_q.push_back(rsp_data);
            if (wr_e && sel == 2'd2 && bus.wr_data[1]) rsp_q.delete();
            if (ovf_set) m_ovf = 1'b1;
            else if (wr_e && sel == 2'd1 && bus.wr_data[31]) m_ovf = 1'b0;
            if (unf_set) m_unf = 1'b1;
            else if (wr_e && sel == 2'd1 && bus.wr_data[30]) m_unf = 1'b0;
            if (rd_e) m_rd_data = rd_val;
            m_rsp_ready = rsp_q.size() < DEPTH;
        end

        check("cmd_valid", 32'(cmd_valid), 32'(cmd_q.size() > 0));
        check("cmd_data", cmd_data, (cmd_q.size() > 0) ? cmd_q[0] : 32'h0);
        check("rsp_ready", 32'(rsp_ready), 32'(m_rsp_ready));
        check("rd_data", bus.rd_data, m_rd_data);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.addr = addr; bus.wr_data = data; bus.wr = 1'b1;
        step();
        bus.wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.addr = addr; bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        data = bus.rd_data;
    endtask

    task automatic core_push(input logic [31:0] data);
        rsp_data = data; rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rv;
        reset = 1'b1; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
        bus.addr = 32'h0; bus.wr_data = 32'h0; bus.wr = 1'b0; bus.rd = 1'b0;
        step();
        check("reset_rsp_ready", 32'(rsp_ready), 32'h0);
        check("reset_cmd_valid", 32'(cmd_valid), 32'h0);
        reset = 1'b0;
        step();
        check("post_reset_rsp_ready", 32'(rsp_ready), 32'h1);
        bus_read(32'h4, rv);
        check("reset_status", rv, 32'h0);

        // Fill: 17 writes, the 17th overflows
        for (int i = 1; i <= 17; i++) bus_write(32'h0, 32'(i));
        bus_read(32'h4, rv);
        check("fill_status", rv, 32'h8000_1001);
        core_rx.delete();
        cmd_ready = 1'b1;
        for (int i = 0; i < 18; i++) step();
        cmd_ready = 1'b0;
        check("drain_count", 32'(core_rx.size()), 32'd16);
        for (int i = 0; i < 16 && i < core_rx.size(); i++) check("drain_word", core_rx[i], 32'(i + 1));
        bus_write(32'h4, 32'h8000_0000);

        // Responses, then underflow read
        core_push(32'hCAFE_0001);
        core_push(32'hCAFE_0002);
        bus_read(32'h0, rv);
        check("rsp_word0", rv, 32'hCAFE_0001);
        bus_read(32'h0, rv);
        check("rsp_word1", rv, 32'hCAFE_0002);
        bus_read(32'h0, rv);
        check("unf_read", rv, 32'h0);
        bus_read(32'h4, rv);
        check("unf_bit", 32'(rv[30]), 32'h1);

        // W1C of unf only, with ovf also set
        for (int i = 0; i < 17; i++) bus_write(32'h0, 32'h100 + 32'(i));
        bus_write(32'h4, 32'h4000_0000);
        bus_read(32'h4, rv);
        check("w1c_bits", 32'(rv[31:30]), 32'h2);

        // Full command FIFO: write plus core pop in one cycle
        cmd_ready = 1'b1;
        bus_write(32'h0, 32'hBEEF_0000);
        cmd_ready = 1'b0;
        bus_read(32'h4, rv);
        check("full_wr_pop_count", 32'(rv[15:8]), 32'd16);

        // Flush both full FIFOs, then ID
        for (int i = 0; i < DEPTH; i++) core_push(32'hA000_0000 + 32'(i));
        check("rsp_full_ready", 32'(rsp_ready), 32'h0);
        bus_write(32'h8, 32'h3);
        check("flush_cmd_valid", 32'(cmd_valid), 32'h0);
        check("flush_rsp_ready", 32'(rsp_ready), 32'h1);
        bus_read(32'h4, rv);
        check("flush_counts", rv & 32'h00FF_FF03, 32'h0);
        bus_read(32'hC, rv);
        check("id", rv, ID);
        bus_read(32'hFFFF_FF0C, rv);
        check("id_alias", rv, ID);

        // Reset mid-traffic
        for (int i = 0; i < 5; i++) bus_write(32'h0, 32'h500 + 32'(i));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_cmd_valid", 32'(cmd_valid), 32'h0);
        check("midreset_rd_data", bus.rd_data, 32'h0);
        bus_read(32'h4, rv);
        check("midreset_status", rv, 32'h0);

        // Randomized traffic in four load phases
        for (int i = 0; i < 3000; i++) begin
            int          phase;
            logic [31:0] a;
            logic [1:0]  off;
            phase = i / 750;
            a     = $urandom();
            off   = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            a[3:2] = off;
            bus.addr    = a;
            bus.wr_data = $urandom();
            if (off == 2'd2 && $urandom_range(0, 15) != 0) bus.wr_data[1:0] = 2'b00;
            bus.wr    = $urandom_range(0, 99) < (phase == 0 ? 55 : phase == 1 ? 10 : 30);
            bus.rd    = $urandom_range(0, 99) < (phase == 0 ? 10 : phase == 1 ? 60 : 30);
            cmd_ready = $urandom_range(0, 99) < (phase == 0 ? 15 : 60);
            rsp_valid = $urandom_range(0, 99) < (phase == 1 ? 20 : 60);
            rsp_data  = $urandom();
            reset     = (phase == 3) && ($urandom_range(0, 199) == 0);
            step();
        end
        bus.wr = 1'b0; bus.rd = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bridge_mailbox.md
# bridge_mailbox

Leaf-side responder for the Pocket bridge bus. It sits on one `bridge_out[n]` port of the bridge splitter and exposes a host-to-core command FIFO and a core-to-host response FIFO through a four-word register window. Bridge writes are pushed to the core, and core responses are popped by bridge reads. Status and flush controls are included for host-side flow control.

## Interface
Parameters:
- `DEPTH`, default 16: entries per FIFO; power of two, 2..128.
- `MAILBOX_ID`, default 32'h4D42_0001: constant returned at offset 0xC.

Ports:
- `bridge.clk`  input  1: sole clock, carried inside `bridge_if`; all logic is on its rising edge.
- `reset`  input  1: reset is synchronous and active-high.
- `bridge`  `bridge_if` leaf side: `addr` in 32, `wr_data` in 32, `wr` in 1, `rd` in 1, `rd_data` out 32.
- `cmd_data`  output  32: head of the command FIFO.
- `cmd_valid`  output  1: command FIFO is not empty.
- `cmd_ready`  input  1: core pops the command FIFO when `cmd_valid && cmd_ready`.
- `rsp_data`  input  32: response word from the core.
- `rsp_valid`  input  1: core offers a response.
- `rsp_ready`  output  1: response FIFO is not full.

## Operation
- Decode uses `addr[3:2]` only. Other address bits are ignored because the splitter has already range-selected this leaf.
- Offset 0x0 DATA:
  - Write pushes `wr_data` to the command FIFO.
  - Read pops the response FIFO and returns the popped word.
- Offset 0x4 STATUS, read layout:
  - [31] `ovf`, [30] `unf`.
  - [23:16] response count, zero-extended.
  - [15:8] command count, zero-extended.
  - [1] response FIFO not empty, [0] command FIFO full.
  - All other bits read 0.
- Offset 0x4 STATUS, write: W1C. `wr_data[31]` clears `ovf`; `wr_data[30]` clears `unf`.
- Offset 0x8 CTRL, write only; reads return 0.
  - `wr_data[0]` flushes the command FIFO.
  - `wr_data[1]` flushes the response FIFO.
  - Flush is a single-cycle action and does not alter the sticky bits.
- Offset 0xC ID: read returns `MAILBOX_ID`; writes are ignored.
- Write to DATA when the command FIFO is full:
  - Word is dropped and `ovf` is set.
  - Exception: if a core pop happens in the same cycle, the write is accepted and the count is unchanged.
- Read of DATA when the response FIFO is empty:
  - Returns 32'h0 and sets `unf`; nothing is popped.
  - A core push in the same cycle does not fall through; it is stored.
- Core push to the response FIFO happens when `rsp_valid && rsp_ready`.
  - If the FIFO is full and a bridge pop occurs in the same cycle, `rsp_ready` still reads 0. Full is evaluated before pops.
- Sticky precedence: a set event in the same cycle as a W1C clear of that bit wins; the bit stays 1.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally; count is `$clog2(DEPTH)+1` bits, 0..DEPTH.
- Flush precedence: flush in the same cycle as a core pop or push forces the count to 0. The concurrent push is discarded.
- `wr` and `rd` asserted together are not legal bus behaviour. If seen, only `wr` is honoured.

## Timing
- Reset values:
  - `rd_data`=0, `cmd_valid`=0, `cmd_data`=0.
  - `rsp_ready`=1 one cycle after reset deasserts; 0 while `reset` is high.
  - Both FIFOs empty; `ovf` and `unf` cleared.
- Reset asserted mid-operation flushes both FIFOs at the next edge. All FIFO contents are lost.
- Read latency is 1 cycle. `rd_data` is registered on the edge where `rd`=1 and holds until the next `rd`.
- Status read reflects state before any same-cycle updates.
- A bridge write is visible on `cmd_valid`/`cmd_data` the cycle after `wr` (registered, no bypass).
- A core pop updates `cmd_data` to the next entry the following cycle.
- A response pushed in cycle N is readable by a bridge `rd` in cycle N+1 or later.
- Throughput: one bridge operation and one core operation per FIFO per cycle. Back-to-back `rd` or `wr` cycles are supported.

## Test plan
- Fill test (DEPTH=16), core `cmd_ready`=0:
  - Write 17 words 1..17 to 0x0 -> STATUS reads 32'h8000_1001 (`ovf`, count 16, full).
  - Core then drains and receives words 1..16 in order; word 17 was dropped.
- Core pushes 32'hCAFE_0001, 32'hCAFE_0002:
  - Two DATA reads, each sampled one cycle after `rd`, return those values in order.
  - A third read returns 0 and STATUS[30]=1.
- W1C: with `ovf`=`unf`=1, write 32'h4000_0000 to 0x4 -> STATUS[31:30]=2'b10.
- Same-cycle events:
  - `ovf` set-event plus W1C of bit 31 -> bit stays 1.
  - Full command FIFO with bridge write plus core pop in one cycle -> write accepted, count stays 16.
- Flush and ID: fill both FIFOs, write 32'h3 to 0x8 -> both counts 0 next cycle, `cmd_valid`=0, `rsp_ready`=1. Read 0xC -> 32'h4D42_0001.
- Reset mid-traffic: 5 commands queued -> assert `reset` 1 cycle -> `cmd_valid`=0, `rd_data`=0, STATUS reads 0.
